cpu_trace_buffer: RTL



---
 rtl/cpu_trace_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// Trace capture buffer: records {timestamp, control state, channel words} into a circular RAM.
// Latency: a capture lands in the RAM and count on the sampling edge; rd_req -> rd_valid is 1 cycle.
// Backpressure: none; there is no input stall. Readout is pull-only via rd_req in DONE, and rd_req is ignored when the buffer is empty.
module cpu_trace_buffer #(
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 4,
   parameter int STATE_W  = 4,
   parameter int DEPTH    = 64,
   localparam int ENTRY_W = 16 + STATE_W + CHANNELS*DATA_W,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sample_en,
   input  logic [STATE_W-1:0]         state_in,
   input  logic [CHANNELS*DATA_W-1:0] ch_data,
   input  logic                       arm,
   input  logic                       stop,
   input  logic [1:0]                 trig_mode,
   input  logic [STATE_W-1:0]         trig_state,
   input  logic                       chg_only,
   input  logic                       wrap_en,
   input  logic                       rd_req,
   output logic                       rd_valid,
   output logic [ENTRY_W-1:0]         rd_data,
   output logic [CW-1:0]              count,
   output logic [1:0]                 status,
   output logic                       overflow
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [1:0]          status_q, status_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [15:0]         ts_q, ts_d;
   logic [STATE_W-1:0]  prev_state_q;
   logic                rd_valid_q;
   logic [ENTRY_W-1:0]  rd_data_q;

   logic [ENTRY_W-1:0]  mem [DEPTH];

   logic                state_chg;
   logic                trig_hit;
   logic                wr_en;
   logic                rd_go;
   logic                clr;
   logic [ENTRY_W-1:0]  entry;

   // The entry carries the timestamp of the cycle on which it is captured.
   assign entry = {ts_q, state_in, ch_data};

   // Trigger qualification, state sequencing and pointer/count bookkeeping.
   always_comb begin
      state_chg  = sample_en && (state_in != prev_state_q);
      case (trig_mode)
         2'd0:    trig_hit = sample_en;
         2'd1:    trig_hit = state_chg;
         2'd2:    trig_hit = sample_en && (state_in == trig_state);
         default: trig_hit = 1'b0;
      endcase

      status_d   = status_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      ts_d       = ts_q + 16'd1;
      wr_en      = 1'b0;
      rd_go      = 1'b0;
      clr        = 1'b0;

      case (status_q)
         ST_IDLE: begin
            if (arm) begin
               clr      = 1'b1;
               status_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // stop has priority over a trigger on the same cycle
            if (stop) begin
               status_d = ST_DONE;
            end else if (trig_hit) begin
               wr_en    = 1'b1;
               status_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (sample_en && (!chg_only || state_chg)) begin
               // wrap_en dropped while full: refuse to overwrite, just finish
               if (count_q == FULL && !wrap_en)
                  status_d = ST_DONE;
               else
                  wr_en = 1'b1;
            end
            if (stop)
               status_d = ST_DONE;
         end
         default: begin
            if (arm) begin
               clr      = 1'b1;
               status_d = ST_ARMED;
            end else if (rd_req && count_q != '0) begin
               rd_go = 1'b1;
            end
         end
      endcase

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (count_q == FULL) begin
            // full and wrapping: oldest entry is lost
            rd_ptr_d   = rd_ptr_q + 1'b1;
            overflow_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
            if (!wrap_en && (count_q + 1'b1) == FULL)
               status_d = ST_DONE;
         end
      end

      if (rd_go) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         count_d  = count_q - 1'b1;
      end

      if (clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         ts_d       = 16'd0;
      end
   end

   // Control registers, timestamp, previous-state tracker and read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         status_q     <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         ts_q         <= 16'd0;
         prev_state_q <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         status_q   <= status_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         ts_q       <= ts_d;
         rd_valid_q <= rd_go;
         if (sample_en)
            prev_state_q <= state_in;
         if (rd_go)
            rd_data_q <= mem[rd_ptr_q];
      end
   end

   // Trace RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_en)
         mem[wr_ptr_q] <= entry;
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign status   = status_q;
   assign overflow = overflow_q;

endmodule
